// File: rtl/arm_pkg.sv
// Shared definitions for the arm_processor pipeline: fetch FSM encoding and
// fetch address constants.
package arm_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2,
    FETCH_SKID = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INSTR_BYTES      = 4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry parking register for a fetched word that arrived while the
// IF/ID output register was frozen with a live instruction.
module fetch_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [DATA_W-1:0] i_instr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;

  // Park a word on load; a clear (unload or branch flush) wins over load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a req/ack instruction memory
// port of variable latency, and presents {valid, pc+4, instr} to IF/ID.
module fetch_stage
  import arm_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_instr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

  fetch_state_t      r_state;
  fetch_state_t      w_nextState;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_addrQ;
  logic              r_ifValid;
  logic [ADDR_W-1:0] r_ifPc;
  logic [DATA_W-1:0] r_ifInstr;

  logic              w_canIssue;
  logic              w_issuePc;
  logic              w_issueBranch;
  logic              w_pcToBranch;
  logic              w_captureMem;
  logic              w_captureSkid;
  logic              w_skidLoad;
  logic              w_skidClear;
  logic              w_skidValid;
  logic [ADDR_W-1:0] w_skidPc;
  logic [DATA_W-1:0] w_skidInstr;

  assign w_canIssue  = !(freeze && r_ifValid);
  assign w_skidClear = branch_taken || w_captureSkid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= FETCH_IDLE;
    else      r_state <= w_nextState;
  end

  // Next state plus the datapath strobes for this cycle; a branch always beats freeze.
  always_comb begin
    w_nextState   = r_state;
    w_issuePc     = 1'b0;
    w_issueBranch = 1'b0;
    w_pcToBranch  = 1'b0;
    w_captureMem  = 1'b0;
    w_captureSkid = 1'b0;
    w_skidLoad    = 1'b0;
    unique case (r_state)
      FETCH_IDLE: begin
        if (branch_taken) begin
          w_issueBranch = 1'b1;
          w_nextState   = FETCH_REQ;
        end else if (w_canIssue) begin
          w_issuePc   = 1'b1;
          w_nextState = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        if (imem_ack && branch_taken) begin
          w_issueBranch = 1'b1;
        end else if (branch_taken) begin
          w_pcToBranch = 1'b1;
          w_nextState  = FETCH_DROP;
        end else if (imem_ack && (!freeze || !r_ifValid)) begin
          w_captureMem = 1'b1;
          if (!freeze) w_issuePc   = 1'b1;
          else         w_nextState = FETCH_IDLE;
        end else if (imem_ack) begin
          w_skidLoad  = 1'b1;
          w_nextState = FETCH_SKID;
        end
      end
      FETCH_DROP: begin
        if (branch_taken) w_pcToBranch = 1'b1;
        if (imem_ack)     w_nextState  = FETCH_IDLE;
      end
      FETCH_SKID: begin
        if (branch_taken) begin
          w_pcToBranch = 1'b1;
          w_nextState  = FETCH_IDLE;
        end else if (!freeze && w_skidValid) begin
          w_captureSkid = 1'b1;
          w_nextState   = FETCH_IDLE;
        end
      end
      default: w_nextState = FETCH_IDLE;
    endcase
  end

  // Memory port outputs: a request is live while waiting for data, including a dropped one.
  always_comb begin
    imem_req  = (r_state == FETCH_REQ) || (r_state == FETCH_DROP);
    imem_addr = r_addrQ;
  end

  // PC and fetch-address registers; addresses wrap modulo 2^ADDR_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_addrQ <= '0;
    end else if (w_issueBranch) begin
      r_addrQ <= branch_addr;
      r_pc    <= branch_addr + STEP;
    end else if (w_issuePc) begin
      r_addrQ <= r_pc;
      r_pc    <= r_pc + STEP;
    end else if (w_pcToBranch) begin
      r_pc <= branch_addr;
    end
  end

  // IF/ID output register: flush on branch, load on capture, drop the bubble when not frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifValid <= 1'b0;
      r_ifPc    <= '0;
      r_ifInstr <= '0;
    end else if (branch_taken) begin
      r_ifValid <= 1'b0;
    end else if (w_captureMem) begin
      r_ifValid <= 1'b1;
      r_ifPc    <= r_addrQ + STEP;
      r_ifInstr <= imem_rdata;
    end else if (w_captureSkid) begin
      r_ifValid <= 1'b1;
      r_ifPc    <= w_skidPc;
      r_ifInstr <= w_skidInstr;
    end else if (!freeze) begin
      r_ifValid <= 1'b0;
    end
  end

  assign if_valid = r_ifValid;
  assign if_pc    = r_ifPc;
  assign if_instr = r_ifInstr;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skidLoad),
    .i_clear (w_skidClear),
    .i_pc    (r_addrQ + STEP),
    .i_instr (imem_rdata),
    .o_valid (w_skidValid),
    .o_pc    (w_skidPc),
    .o_instr (w_skidInstr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a directed per-cycle vector table, an async
// reset sequence, then randomized traffic against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct packed {
    logic        f;
    logic        b;
    logic [31:0] baddr;
    logic        ack;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs [25];

  // Memory contents as a pure function of the byte address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mkVec(input logic f, input logic b, input logic [31:0] ba,
                                 input logic ack, input logic er, input logic [31:0] ea,
                                 input logic ev, input logic [31:0] ep);
    vec_t v;
    v.f = f; v.b = b; v.baddr = ba; v.ack = ack;
    v.expReq = er; v.expAddr = ea; v.expValid = ev; v.expPc = ep;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic b, input logic [31:0] ba,
                               input logic ack, input logic [31:0] rdata);
    freeze       = f;
    branch_taken = b;
    branch_addr  = ba;
    imem_ack     = ack;
    imem_rdata   = rdata;
  endtask

  // Transaction-level reference: an outstanding fetch (possibly doomed),
  // an optional parked word, the next PC, and the delivered instruction.
  bit          mReq, mDiscard, mPark, mOutValid;
  logic [31:0] mPc, mAddr, mParkPc, mParkInstr, mOutPc, mOutInstr;

  task automatic modelReset();
    mReq = 0; mDiscard = 0; mPark = 0; mOutValid = 0;
    mPc = 32'h0; mAddr = 32'h0; mParkPc = 0; mParkInstr = 0; mOutPc = 0; mOutInstr = 0;
  endtask

  task automatic modelStep(input bit f, input bit b, input logic [31:0] ba,
                           input bit a, input logic [31:0] d);
    bit nReq = mReq, nDiscard = mDiscard, nPark = mPark, nOutValid = mOutValid;
    logic [31:0] nPc = mPc, nAddr = mAddr, nParkPc = mParkPc, nParkInstr = mParkInstr;
    logic [31:0] nOutPc = mOutPc, nOutInstr = mOutInstr;
    bit delivered = 0;
    if (mPark) begin
      if (b) nPc = ba;
      else if (!f) begin
        nOutPc = mParkPc; nOutInstr = mParkInstr; nOutValid = 1; delivered = 1; nPark = 0;
      end
    end else if (!mReq) begin
      if (b) begin nAddr = ba; nPc = ba + 4; nReq = 1; end
      else if (!(f && mOutValid)) begin nAddr = mPc; nPc = mPc + 4; nReq = 1; end
    end else if (mDiscard) begin
      if (b) nPc = ba;
      if (a) begin nReq = 0; nDiscard = 0; end
    end else begin
      if (a && b) begin nAddr = ba; nPc = ba + 4; end
      else if (b) begin nPc = ba; nDiscard = 1; end
      else if (a && (!f || !mOutValid)) begin
        nOutInstr = d; nOutPc = mAddr + 4; nOutValid = 1; delivered = 1;
        if (!f) begin nAddr = mPc; nPc = mPc + 4; end
        else nReq = 0;
      end else if (a) begin
        nPark = 1; nParkPc = mAddr + 4; nParkInstr = d; nReq = 0;
      end
    end
    if (b) begin nOutValid = 0; nPark = 0; end
    else if (!delivered && !f) nOutValid = 0;
    mReq = nReq; mDiscard = nDiscard; mPark = nPark; mOutValid = nOutValid;
    mPc = nPc; mAddr = nAddr; mParkPc = nParkPc; mParkInstr = nParkInstr;
    mOutPc = nOutPc; mOutInstr = nOutInstr;
  endtask

  // Stimulus and checking sequence.
  initial begin
    int memLeft;
    // Directed per-cycle table; each row gives outputs seen before the edge and inputs for it.
    vecs[0]  = mkVec(0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0);
    vecs[1]  = mkVec(0, 0, 32'h0,         1, 1, 32'h0,         0, 32'h0);
    vecs[2]  = mkVec(0, 0, 32'h0,         1, 1, 32'h4,         1, 32'h4);
    vecs[3]  = mkVec(0, 0, 32'h0,         0, 1, 32'h8,         1, 32'h8);
    vecs[4]  = mkVec(0, 0, 32'h0,         0, 1, 32'h8,         0, 32'h8);
    vecs[5]  = mkVec(0, 0, 32'h0,         1, 1, 32'h8,         0, 32'h8);
    vecs[6]  = mkVec(0, 0, 32'h0,         1, 1, 32'hC,         1, 32'hC);
    vecs[7]  = mkVec(0, 1, 32'h100,       0, 1, 32'h10,        1, 32'h10);
    vecs[8]  = mkVec(0, 0, 32'h0,         0, 1, 32'h10,        0, 32'h10);
    vecs[9]  = mkVec(0, 0, 32'h0,         1, 1, 32'h10,        0, 32'h10);
    vecs[10] = mkVec(0, 0, 32'h0,         0, 0, 32'h10,        0, 32'h10);
    vecs[11] = mkVec(0, 0, 32'h0,         1, 1, 32'h100,       0, 32'h10);
    vecs[12] = mkVec(1, 0, 32'h0,         1, 1, 32'h104,       1, 32'h104);
    vecs[13] = mkVec(1, 0, 32'h0,         0, 0, 32'h104,       1, 32'h104);
    vecs[14] = mkVec(1, 0, 32'h0,         0, 0, 32'h104,       1, 32'h104);
    vecs[15] = mkVec(0, 0, 32'h0,         0, 0, 32'h104,       1, 32'h104);
    vecs[16] = mkVec(0, 0, 32'h0,         0, 0, 32'h104,       1, 32'h108);
    vecs[17] = mkVec(0, 0, 32'h0,         1, 1, 32'h108,       0, 32'h108);
    vecs[18] = mkVec(1, 0, 32'h0,         1, 1, 32'h10C,       1, 32'h10C);
    vecs[19] = mkVec(1, 1, 32'h200,       0, 0, 32'h10C,       1, 32'h10C);
    vecs[20] = mkVec(0, 0, 32'h0,         0, 0, 32'h10C,       0, 32'h10C);
    vecs[21] = mkVec(0, 0, 32'h0,         1, 1, 32'h200,       0, 32'h10C);
    vecs[22] = mkVec(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h204,       1, 32'h204);
    vecs[23] = mkVec(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, 32'h204);
    vecs[24] = mkVec(0, 0, 32'h0,         0, 1, 32'h0,         1, 32'h0);

    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 25; i++) begin
      checkOutput($sformatf("vec%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].expReq});
      checkOutput($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d if_pc", i), if_pc, vecs[i].expPc);
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d if_instr", i), if_instr, memWord(vecs[i].expPc - 32'd4));
      applyStimulus(vecs[i].f, vecs[i].b, vecs[i].baddr, vecs[i].ack,
                    vecs[i].ack ? memWord(vecs[i].expAddr) : 32'hDEAD_BEEF);
      @(posedge clk);
      @(negedge clk);
    end

    // Async reset in the middle of an outstanding request.
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async imem_req", {31'b0, imem_req}, 32'h0);
    checkOutput("async imem_addr", imem_addr, 32'h0);
    checkOutput("async if_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("async if_pc", if_pc, 32'h0);
    checkOutput("async if_instr", if_instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart imem_req", {31'b0, imem_req}, 32'h1);
    checkOutput("restart imem_addr", imem_addr, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, memWord(32'h0));
    @(posedge clk);
    @(negedge clk);
    checkOutput("restart if_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("restart if_pc", if_pc, 32'h4);
    checkOutput("restart if_instr", if_instr, memWord(32'h0));

    // Randomized traffic against the reference model.
    applyStimulus(0, 0, 32'h0, 0, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    memLeft = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit          f, b, a, reqNow;
      logic [31:0] ba, d;
      checkOutput("rand imem_req", {31'b0, imem_req}, {31'b0, mReq});
      checkOutput("rand imem_addr", imem_addr, mAddr);
      checkOutput("rand if_valid", {31'b0, if_valid}, {31'b0, mOutValid});
      checkOutput("rand if_pc", if_pc, mOutPc);
      checkOutput("rand if_instr", if_instr, mOutInstr);
      f  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       ba = 32'hFFFF_FFFC;
        1:       ba = 32'hFFFF_FFF8;
        default: ba = $urandom() & 32'hFFFF_FFFC;
      endcase
      reqNow = mReq;
      if (reqNow && memLeft < 0) memLeft = $urandom_range(0, 3);
      a = reqNow && (memLeft == 0);
      d = a ? memWord(mAddr) : $urandom();
      applyStimulus(f, b, ba, a, d);
      modelStep(f, b, ba, a, d);
      @(posedge clk);
      if (a) memLeft = -1;
      else if (reqNow) memLeft--;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
